rcv_crc16_check: RTL and testbench
==================================

# rcv_crc16_check

Data-packet CRC16 checker and trailer stripper in the USB receiver path. It accepts decoded bytes from the receive byte assembler and runs the USB CRC16 over every byte of the packet. It holds the newest two bytes back so that only payload bytes reach the data FIFO, and reports pass/fail at end of packet.

## Interface
- No parameters. Data width is fixed at 8 bits; the CRC constants live in the package.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- pkt_start  in  1  one-cycle pulse: a DATA PID was accepted and payload bytes follow.
- byte_valid  in  1  one-cycle pulse: rcv_byte holds a new decoded byte.
- rcv_byte  in  8  decoded byte, bit 0 first on the wire.
- eop  in  1  one-cycle pulse: end of packet detected.
- fifo_full  in  1  full flag from the downstream data FIFO.
- data_out  out  8  payload byte to the data FIFO.
- data_wen  out  1  write strobe to the data FIFO, one cycle per byte.
- pkt_done  out  1  one-cycle pulse: the check result is valid.
- crc_ok  out  1  last packet passed; held until the next pkt_start.
- crc_err  out  1  last packet failed (CRC, short packet or overflow); held until the next pkt_start.
- trl_data  out  8  stripped trailer byte (CRC_TRAILER_TAP_EN only; tied 0 otherwise).
- trl_wen  out  1  trailer write strobe (CRC_TRAILER_TAP_EN only; tied 0 otherwise).

## Operation
- States:
  - IDLE: waiting for a packet.
  - RCV: receiving a packet.
  - TRAIL: draining the trailer; present only with the macro.
- IDLE -> RCV on pkt_start. In RCV, a further pkt_start aborts the current packet and restarts: crc, hold count and flags are cleared and nothing is emitted.
- On entry to RCV: crc <= 16'hFFFF, hold buffer count <= 0, ovf <= 0, crc_ok <= 0, crc_err <= 0.
- CRC update per byte, processing bits 0 to 7 in order. For each bit b:
  - fb = crc[15] ^ b
  - crc = {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 16'h0)
  - All 8 bits are unrolled into a single cycle.
- Hold buffer: a 2-entry shift register (h1 newest, h0 oldest) with count 0..2. On byte_valid:
  - If count < 2, the byte shifts in and count increments.
  - If count == 2, h0 is pushed to the data FIFO and the new byte shifts in.
- A push while fifo_full is high drops the byte and sets ovf; CRC accumulation continues regardless.
- eop in RCV sets pkt_done and latches the result:
  - crc_ok = (crc == 16'h800D) && (count == 2) && !ovf
  - crc_err = !crc_ok
  - Next state is IDLE, or TRAIL with the macro.
- byte_valid and eop in the same cycle: the byte is fully processed (CRC and hold buffer) first, and the check uses the updated values.
- byte_valid or eop while in IDLE is ignored.

## Timing
- Every output is registered. Reset values: data_out 0, data_wen 0, pkt_done 0, crc_ok 0, crc_err 0, trl_data 0, trl_wen 0, state IDLE, crc 16'hFFFF, count 0.
- data_wen and data_out are asserted in the cycle after the byte_valid that displaced h0.
- pkt_done, crc_ok and crc_err update in the cycle after eop.
- Back-to-back byte_valid on consecutive cycles is supported at full rate.
- Reset asserted mid-packet returns the block to IDLE immediately. No partial writes or pulses follow reset release.

## Configuration
- CRC_TRAILER_TAP_EN defined:
  - After eop, TRAIL emits h0 and then h1 on trl_data with trl_wen, one per cycle, starting the cycle after pkt_done. Then the block returns to IDLE.
  - Fewer than 2 held bytes emits only what is held.
  - pkt_start during TRAIL aborts the drain and enters RCV.
- CRC_TRAILER_TAP_EN undefined: there is no TRAIL state, the trailer is discarded, and trl_data and trl_wen are tied 0.

## Structure
- Package rcv_crc_pkg holds:
  - CRC16_POLY 16'h8005, CRC16_INIT 16'hFFFF, CRC16_RESIDUAL 16'h800D.
  - The state enum typedef.
- One combinational sub-module, crc16_byte_step, with inputs crc_in[15:0] and byte_in[7:0] and output crc_out[15:0]. It is reusable by the token CRC path.
- The top level holds the state machine, hold buffer, flags and output registers.

## Test plan
- Zero-length packet: pkt_start, bytes 8'h00, 8'h00, eop -> no data_wen; pkt_done with crc_ok=1, crc_err=0.
- Zero-length packet with bad trailer 8'h00, 8'h01 -> crc_err=1, crc_ok=0, no data_wen.
- Payload 8'h5A followed by its correct two CRC bytes (computed by the model) -> exactly one data_wen with data_out=8'h5A; crc_ok=1.
- Single byte then eop -> crc_err=1 (short packet). Same for no bytes at all.
- fifo_full held high over a 4-payload-byte packet with correct CRC -> no data_wen; crc_err=1 from overflow.
- Protocol and reset edge cases:
  - byte_valid coincident with eop on the last CRC byte -> crc_ok=1.
  - n_rst pulsed low mid-packet, then a clean zero-length packet -> crc_ok=1.
  - With the macro, trl_wen pulses twice carrying the two trailer bytes in order.

Source files
------------

// File: rtl/rcv_crc_pkg.sv
// Shared constants and state type for the USB receive-path CRC16 checker.
// The TRAIL state exists only when CRC_TRAILER_TAP_EN is defined.
package rcv_crc_pkg;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef CRC_TRAILER_TAP_EN
        ST_RCV   = 2'd1,
        ST_TRAIL = 2'd2
`else
        ST_RCV   = 2'd1
`endif
    } state_e;

endpackage : rcv_crc_pkg

// File: rtl/crc16_byte_step.sv
// One-byte USB CRC16 update, bit 0 of the byte processed first, fully unrolled.
// Pure combinational so the token CRC path can reuse it.
module crc16_byte_step
    import rcv_crc_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_v;

    always_comb begin
        crc_v = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_v[15] ^ byte_in[i]) begin
                crc_v = {crc_v[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                crc_v = {crc_v[14:0], 1'b0};
            end
        end
        crc_out = crc_v;
    end

endmodule : crc16_byte_step

// File: rtl/rcv_crc16_check.sv
// DATA-packet CRC16 checker: holds back the newest two bytes (the CRC trailer) so only
// payload reaches the data FIFO. Define CRC_TRAILER_TAP_EN to replay the trailer on trl_*.
module rcv_crc16_check
    import rcv_crc_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       pkt_start,
    input  logic       byte_valid,
    input  logic [7:0] rcv_byte,
    input  logic       eop,
    input  logic       fifo_full,
    output logic [7:0] data_out,
    output logic       data_wen,
    output logic       pkt_done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic [7:0] trl_data,
    output logic       trl_wen
);

    state_e      state_q, state_d;
    logic [15:0] crc_q, crc_d, crc_step;
    logic [7:0]  h0_q, h0_d, h1_q, h1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_wen_q, data_wen_d;
    logic        pkt_done_q, pkt_done_d;
    logic        crc_ok_q, crc_ok_d;
    logic        crc_err_q, crc_err_d;

    logic [15:0] crc_nx;
    logic [7:0]  h0_nx, h1_nx;
    logic [1:0]  cnt_nx;
    logic        ovf_nx, push, ok_nx;

    crc16_byte_step u_step (
        .crc_in  (crc_q),
        .byte_in (rcv_byte),
        .crc_out (crc_step)
    );

    // Effect of the current byte; eop in the same cycle judges these updated values.
    always_comb begin
        crc_nx = crc_q;
        h0_nx  = h0_q;
        h1_nx  = h1_q;
        cnt_nx = cnt_q;
        ovf_nx = ovf_q;
        push   = 1'b0;
        if (byte_valid) begin
            crc_nx = crc_step;
            h0_nx  = h1_q;
            h1_nx  = rcv_byte;
            if (cnt_q == 2'd2) begin
                if (fifo_full) begin
                    ovf_nx = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end else begin
                cnt_nx = cnt_q + 2'd1;
            end
        end
        ok_nx = (crc_nx == CRC16_RESIDUAL) && (cnt_nx == 2'd2) && !ovf_nx;
    end

`ifdef CRC_TRAILER_TAP_EN
    logic [7:0] trl_data_q, trl_data_d;
    logic       trl_wen_q, trl_wen_d;
    assign trl_data = trl_data_q;
    assign trl_wen  = trl_wen_q;
`else
    assign trl_data = 8'h00;
    assign trl_wen  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        h0_d       = h0_q;
        h1_d       = h1_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        data_out_d = data_out_q;
        data_wen_d = 1'b0;
        pkt_done_d = 1'b0;
        crc_ok_d   = crc_ok_q;
        crc_err_d  = crc_err_q;
`ifdef CRC_TRAILER_TAP_EN
        trl_data_d = trl_data_q;
        trl_wen_d  = 1'b0;
`endif
        // pkt_start restarts from any state, abandoning whatever was in progress.
        if (pkt_start) begin
            state_d   = ST_RCV;
            crc_d     = CRC16_INIT;
            cnt_d     = 2'd0;
            ovf_d     = 1'b0;
            crc_ok_d  = 1'b0;
            crc_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_RCV: begin
                    crc_d = crc_nx;
                    h0_d  = h0_nx;
                    h1_d  = h1_nx;
                    cnt_d = cnt_nx;
                    ovf_d = ovf_nx;
                    if (push) begin
                        data_out_d = h0_q;
                        data_wen_d = 1'b1;
                    end
                    if (eop) begin
                        pkt_done_d = 1'b1;
                        crc_ok_d   = ok_nx;
                        crc_err_d  = !ok_nx;
`ifdef CRC_TRAILER_TAP_EN
                        state_d    = ST_TRAIL;
`else
                        state_d    = ST_IDLE;
`endif
                    end
                end
`ifdef CRC_TRAILER_TAP_EN
                ST_TRAIL: begin
                    if (cnt_q == 2'd2) begin
                        trl_data_d = h0_q;
                        trl_wen_d  = 1'b1;
                        cnt_d      = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        trl_data_d = h1_q;
                        trl_wen_d  = 1'b1;
                        cnt_d      = 2'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            crc_q      <= CRC16_INIT;
            h0_q       <= 8'h00;
            h1_q       <= 8'h00;
            cnt_q      <= 2'd0;
            ovf_q      <= 1'b0;
            data_out_q <= 8'h00;
            data_wen_q <= 1'b0;
            pkt_done_q <= 1'b0;
            crc_ok_q   <= 1'b0;
            crc_err_q  <= 1'b0;
`ifdef CRC_TRAILER_TAP_EN
            trl_data_q <= 8'h00;
            trl_wen_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
            data_wen_q <= data_wen_d;
            pkt_done_q <= pkt_done_d;
            crc_ok_q   <= crc_ok_d;
            crc_err_q  <= crc_err_d;
`ifdef CRC_TRAILER_TAP_EN
            trl_data_q <= trl_data_d;
            trl_wen_q  <= trl_wen_d;
`endif
        end
    end

    assign data_out = data_out_q;
    assign data_wen = data_wen_q;
    assign pkt_done = pkt_done_q;
    assign crc_ok   = crc_ok_q;
    assign crc_err  = crc_err_q;

endmodule : rcv_crc16_check

// File: tb/tb_rcv_crc16_check.sv
// Randomized bench for rcv_crc16_check against a packet-level reference model.
// Trailer checks follow CRC_TRAILER_TAP_EN when it is defined.
`timescale 1ns/1ps
module tb_rcv_crc16_check;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       pkt_start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] rcv_byte = 8'h00;
    logic       eop = 1'b0;
    logic       fifo_full = 1'b0;
    logic [7:0] data_out;
    logic       data_wen;
    logic       pkt_done;
    logic       crc_ok;
    logic       crc_err;
    logic [7:0] trl_data;
    logic       trl_wen;

    int errors = 0;
    int checks = 0;

    logic [7:0] gotData[$];
    logic [7:0] gotTrl[$];
    int         doneCount = 0;
    logic       lastOk = 1'b0;
    logic       lastErr = 1'b0;

    logic [7:0] stimBytes[$];
    bit         stimFull[$];

    always #5 clk = ~clk;

    rcv_crc16_check dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .pkt_start  (pkt_start),
        .byte_valid (byte_valid),
        .rcv_byte   (rcv_byte),
        .eop        (eop),
        .fifo_full  (fifo_full),
        .data_out   (data_out),
        .data_wen   (data_wen),
        .pkt_done   (pkt_done),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .trl_data   (trl_data),
        .trl_wen    (trl_wen)
    );

    // Outputs are collected on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (data_wen) gotData.push_back(data_out);
        if (trl_wen) gotTrl.push_back(trl_data);
        if (pkt_done) begin
            doneCount = doneCount + 1;
            lastOk    = crc_ok;
            lastErr   = crc_err;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // CRC of the first n stimulus bytes, bits fed in wire order (bit 0 first).
    function automatic logic [15:0] crcOfStim(input int n);
        logic [15:0] c;
        bit          fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[15] ^ stimBytes[k][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] bitRev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // The complemented CRC goes out high bit first, so each wire byte is bit-reversed.
    task automatic appendGoodCrc();
        logic [15:0] t;
        t = ~crcOfStim(stimBytes.size());
        stimBytes.push_back(bitRev(t[15:8]));
        stimBytes.push_back(bitRev(t[7:0]));
    endtask

    task automatic clearCapture();
        gotData.delete();
        gotTrl.delete();
        doneCount = 0;
    endtask

    task automatic startPulse();
        pkt_start = 1'b1;
        @(posedge clk); #1;
        pkt_start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit full, input bit withEop);
        byte_valid = 1'b1;
        rcv_byte   = b;
        fifo_full  = full;
        eop        = withEop;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        eop        = 1'b0;
        fifo_full  = 1'b0;
    endtask

    task automatic applyStimulus(input bit coincident, input int gapMax);
        int n;
        n = stimBytes.size();
        while (stimFull.size() < n) stimFull.push_back(1'b0);
        clearCapture();
        startPulse();
        for (int k = 0; k < n; k++) begin
            sendByte(stimBytes[k], stimFull[k], coincident && (k == n - 1));
            for (int g = 0; g < $urandom_range(gapMax, 0); g++) begin
                @(posedge clk); #1;
            end
        end
        if (!coincident || n == 0) begin
            eop = 1'b1;
            @(posedge clk); #1;
            eop = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic verifyPacket(input string tag);
        logic [7:0] expData[$];
        logic [7:0] expTrl[$];
        bit         ovf;
        bit         expOk;
        int         n;
        n   = stimBytes.size();
        ovf = 1'b0;
        for (int k = 2; k < n; k++) begin
            if (stimFull[k]) ovf = 1'b1;
            else expData.push_back(stimBytes[k-2]);
        end
        expOk = (crcOfStim(n) == 16'h800D) && (n >= 2) && !ovf;
        checkOutput({tag, ".doneCount"}, doneCount, 1);
        checkOutput({tag, ".crcOk"}, lastOk, expOk);
        checkOutput({tag, ".crcErr"}, lastErr, !expOk);
        checkOutput({tag, ".okHeld"}, crc_ok, expOk);
        checkOutput({tag, ".errHeld"}, crc_err, !expOk);
        checkOutput({tag, ".wenCount"}, gotData.size(), expData.size());
        for (int i = 0; i < expData.size() && i < gotData.size(); i++)
            checkOutput({tag, ".data"}, gotData[i], expData[i]);
`ifdef CRC_TRAILER_TAP_EN
        if (n >= 2) begin
            expTrl.push_back(stimBytes[n-2]);
            expTrl.push_back(stimBytes[n-1]);
        end else if (n == 1) begin
            expTrl.push_back(stimBytes[0]);
        end
`endif
        checkOutput({tag, ".trlCount"}, gotTrl.size(), expTrl.size());
        for (int i = 0; i < expTrl.size() && i < gotTrl.size(); i++)
            checkOutput({tag, ".trl"}, gotTrl[i], expTrl[i]);
    endtask

    task automatic setStim(input logic [7:0] b0, input logic [7:0] b1, input int n);
        stimBytes.delete();
        stimFull.delete();
        if (n > 0) stimBytes.push_back(b0);
        if (n > 1) stimBytes.push_back(b1);
    endtask

    initial begin
        int mode;
        int len;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.dataOut", data_out, 0);
        checkOutput("rst.dataWen", data_wen, 0);
        checkOutput("rst.pktDone", pkt_done, 0);
        checkOutput("rst.crcOk", crc_ok, 0);
        checkOutput("rst.crcErr", crc_err, 0);
        checkOutput("rst.trlData", trl_data, 0);
        checkOutput("rst.trlWen", trl_wen, 0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        setStim(8'h00, 8'h00, 2);
        applyStimulus(1'b0, 0);
        verifyPacket("zeroLen");

        setStim(8'h00, 8'h01, 2);
        applyStimulus(1'b0, 0);
        verifyPacket("zeroLenBad");

        setStim(8'h5A, 8'h00, 1);
        appendGoodCrc();
        applyStimulus(1'b0, 0);
        verifyPacket("oneByte");

        setStim(8'h77, 8'h00, 1);
        applyStimulus(1'b0, 0);
        verifyPacket("short1");

        setStim(8'h00, 8'h00, 0);
        applyStimulus(1'b0, 0);
        verifyPacket("short0");

        setStim(8'h12, 8'h34, 2);
        stimBytes.push_back(8'h56);
        stimBytes.push_back(8'h78);
        appendGoodCrc();
        for (int k = 0; k < stimBytes.size(); k++) stimFull.push_back(1'b1);
        applyStimulus(1'b0, 0);
        verifyPacket("fifoFull");

        setStim(8'hC3, 8'h3C, 2);
        appendGoodCrc();
        applyStimulus(1'b1, 0);
        verifyPacket("coincidentEop");

        // Abort: a second pkt_start mid-packet must discard the two bytes already held.
        clearCapture();
        startPulse();
        sendByte(8'h11, 1'b0, 1'b0);
        sendByte(8'h22, 1'b0, 1'b0);
        setStim(8'h5A, 8'h00, 1);
        appendGoodCrc();
        applyStimulus(1'b0, 0);
        verifyPacket("abortRestart");

        // Reset mid-packet, landing while a data write strobe is being driven.
        clearCapture();
        startPulse();
        sendByte(8'hA1, 1'b0, 1'b0);
        sendByte(8'hB2, 1'b0, 1'b0);
        sendByte(8'hC3, 1'b0, 1'b0);
        checkOutput("midRst.wenBefore", data_wen, 1);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midRst.wenAsync", data_wen, 0);
        checkOutput("midRst.dataOutAsync", data_out, 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        clearCapture();
        sendByte(8'h44, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("afterRst.noDone", doneCount, 0);
        checkOutput("afterRst.noWen", gotData.size(), 0);
        checkOutput("afterRst.noTrl", gotTrl.size(), 0);
        setStim(8'h00, 8'h00, 2);
        applyStimulus(1'b0, 0);
        verifyPacket("afterRstZeroLen");

        for (int p = 0; p < 40; p++) begin
            stimBytes.delete();
            stimFull.delete();
            mode = $urandom_range(4, 0);
            len  = (mode == 4) ? $urandom_range(2, 0) : $urandom_range(6, 0);
            for (int k = 0; k < len; k++) stimBytes.push_back(8'($urandom));
            if (mode <= 2) begin
                appendGoodCrc();
            end else if (mode == 3) begin
                stimBytes.push_back(8'($urandom));
                stimBytes.push_back(8'($urandom));
            end
            for (int k = 0; k < stimBytes.size(); k++)
                stimFull.push_back((p % 4 == 0) && ($urandom_range(7, 0) == 0));
            applyStimulus(1'($urandom_range(1, 0)), 1);
            verifyPacket($sformatf("rand%0d", p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rcv_crc16_check
